// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads the next PC, runs a req/ack read against instruction
// memory and holds the fetched word, tagged with its PC, for decode under valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       nextPC,
  input  logic              nextPCValid,
  output logic              pcReady,
  output logic [31:0]       memAddr,
  output logic              memReq,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       instrPC,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              flush,
  output logic [31:0]       fetchCount
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t      state, next_state;
  logic [31:0] cur_pc;
  logic        load_pc;
  logic        capture;
  logic        handshake;

  function automatic logic [31:0] inc_wrap(input logic [31:0] val);
    return val + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= REQ;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_pc    = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (nextPCValid) begin
          load_pc    = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (memAck) begin
          if (!flush) begin
            capture    = 1'b1;
            next_state = HOLD;
          end else begin
            next_state = IDLE;
          end
        end else if (flush) begin
          next_state = DROP;
        end
      end
      DROP: begin
        // The read already issued must complete before the bus is free again.
        if (memAck) next_state = IDLE;
      end
      HOLD: begin
        handshake = instrReady & ~flush;
        if (instrReady | flush) begin
          if (nextPCValid) begin
            load_pc    = 1'b1;
            next_state = REQ;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_pc     <= RESET_PC;
      instr      <= '0;
      instrPC    <= '0;
      fetchCount <= '0;
    end else begin
      if (load_pc) cur_pc <= nextPC;
      if (capture) begin
        instr   <= memData;
        instrPC <= cur_pc;
      end
      if (handshake) fetchCount <= inc_wrap(fetchCount);
    end
  end

  assign memReq     = (state == REQ) || (state == DROP);
  assign memAddr    = cur_pc;
  assign instrValid = (state == HOLD) && !flush;
  assign pcReady    = (state == IDLE) || ((state == HOLD) && (instrReady || flush));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetches with wait states,
// backpressure, flushes in flight and in HOLD, counter wrap and reset in DROP.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] nextPC;
  logic        nextPCValid;
  logic        pcReady;
  logic [31:0] memAddr;
  logic        memReq;
  logic        memAck;
  logic [31:0] memData;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        instrValid;
  logic        instrReady;
  logic        flush;
  logic [31:0] fetchCount;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .nextPC(nextPC), .nextPCValid(nextPCValid), .pcReady(pcReady),
    .memAddr(memAddr), .memReq(memReq), .memAck(memAck), .memData(memData),
    .instr(instr), .instrPC(instrPC), .instrValid(instrValid), .instrReady(instrReady),
    .flush(flush), .fetchCount(fetchCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns later and outputs checked 2ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [31:0] data;
    reset = 1'b1; nextPC = '0; nextPCValid = 1'b0; memAck = 1'b0; memData = '0;
    instrReady = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_memReq", {31'd0, memReq}, 32'd1);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_instrValid", {31'd0, instrValid}, 32'd0);
    check("rst_pcReady", {31'd0, pcReady}, 32'd0);
    check("rst_fetchCount", fetchCount, 32'd0);

    // Reset and first fetch: zero-wait ack
    memAck = 1'b1; memData = 32'h20080005;
    tick();
    memAck = 1'b0; memData = '0;
    settle();
    check("f0_valid", {31'd0, instrValid}, 32'd1);
    check("f0_instr", instr, 32'h20080005);
    check("f0_pc", instrPC, 32'd0);
    check("f0_pcReady_stall", {31'd0, pcReady}, 32'd0);
    instrReady = 1'b1; nextPCValid = 1'b1; nextPC = 32'd1;
    settle();
    check("f0_pcReady", {31'd0, pcReady}, 32'd1);
    tick();
    instrReady = 1'b0; nextPCValid = 1'b0;
    settle();
    check("f0_count", fetchCount, 32'd1);

    // Sequential stream, two wait cycles per fetch
    for (int pc = 1; pc <= 3; pc++) begin
      data = 32'hA0000000 + pc;
      for (int w = 0; w < 3; w++) begin
        check("seq_req", {31'd0, memReq}, 32'd1);
        check("seq_addr", memAddr, pc);
        check("seq_novalid", {31'd0, instrValid}, 32'd0);
        if (w == 2) begin memAck = 1'b1; memData = data; end
        tick();
        memAck = 1'b0; memData = '0;
        settle();
      end
      check("seq_valid", {31'd0, instrValid}, 32'd1);
      check("seq_pc", instrPC, pc);
      check("seq_instr", instr, data);
      if (pc < 3) begin
        instrReady = 1'b1; nextPCValid = 1'b1; nextPC = pc + 1;
        tick();
        instrReady = 1'b0; nextPCValid = 1'b0;
        settle();
      end
    end

    // Backpressure in HOLD for 5 cycles
    for (int c = 0; c < 5; c++) begin
      tick(); settle();
      check("bp_valid", {31'd0, instrValid}, 32'd1);
      check("bp_instr", instr, 32'hA0000003);
      check("bp_pc", instrPC, 32'd3);
      check("bp_pcReady", {31'd0, pcReady}, 32'd0);
      check("bp_memReq", {31'd0, memReq}, 32'd0);
      check("bp_count", fetchCount, 32'd3);
    end
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    settle();
    check("seq_count", fetchCount, 32'd4);
    check("idle_pcReady", {31'd0, pcReady}, 32'd1);
    check("idle_memReq", {31'd0, memReq}, 32'd0);

    // Flush while the request is in flight
    nextPCValid = 1'b1; nextPC = 32'h8;
    tick();
    nextPCValid = 1'b0;
    settle();
    check("fl_addr", memAddr, 32'h8);
    flush = 1'b1;
    tick();
    flush = 1'b0; nextPCValid = 1'b1; nextPC = 32'h99;
    settle();
    for (int c = 0; c < 3; c++) begin
      check("drop_memReq", {31'd0, memReq}, 32'd1);
      check("drop_pcReady", {31'd0, pcReady}, 32'd0);
      check("drop_valid", {31'd0, instrValid}, 32'd0);
      check("drop_addr", memAddr, 32'h8);
      if (c == 2) begin memAck = 1'b1; memData = 32'hDEADBEEF; end
      tick();
      memAck = 1'b0; memData = '0;
      settle();
    end
    nextPCValid = 1'b0;
    settle();
    check("drop_idle_memReq", {31'd0, memReq}, 32'd0);
    check("drop_idle_valid", {31'd0, instrValid}, 32'd0);
    check("drop_idle_pcReady", {31'd0, pcReady}, 32'd1);
    nextPCValid = 1'b1; nextPC = 32'h40;
    tick();
    nextPCValid = 1'b0;
    settle();
    check("post_fl_addr", memAddr, 32'h40);
    check("post_fl_req", {31'd0, memReq}, 32'd1);
    memAck = 1'b1; memData = 32'hAABBCCDD;
    tick();
    memAck = 1'b0;
    settle();
    check("post_fl_pc", instrPC, 32'h40);
    check("post_fl_instr", instr, 32'hAABBCCDD);

    // Flush beats ready in HOLD
    flush = 1'b1; instrReady = 1'b1; nextPCValid = 1'b1; nextPC = 32'h10;
    settle();
    check("fr_valid", {31'd0, instrValid}, 32'd0);
    check("fr_pcReady", {31'd0, pcReady}, 32'd1);
    tick();
    flush = 1'b0; instrReady = 1'b0; nextPCValid = 1'b0;
    settle();
    check("fr_count", fetchCount, 32'd4);
    check("fr_addr", memAddr, 32'h10);
    check("fr_req", {31'd0, memReq}, 32'd1);

    // Counter wrap
    memAck = 1'b1; memData = 32'h00001234;
    tick();
    memAck = 1'b0;
    force dut.fetchCount = 32'hFFFFFFFF;
    settle();
    release dut.fetchCount;
    settle();
    check("wrap_pre", fetchCount, 32'hFFFFFFFF);
    instrReady = 1'b1; nextPCValid = 1'b1; nextPC = 32'h20;
    tick();
    instrReady = 1'b0; nextPCValid = 1'b0;
    settle();
    check("wrap_count", fetchCount, 32'd0);
    check("wrap_addr", memAddr, 32'h20);

    // Reset while in DROP
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("rd_drop_req", {31'd0, memReq}, 32'd1);
    check("rd_drop_pcReady", {31'd0, pcReady}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rd_req", {31'd0, memReq}, 32'd1);
    check("rd_addr", memAddr, 32'd0);
    check("rd_valid", {31'd0, instrValid}, 32'd0);
    check("rd_pcReady", {31'd0, pcReady}, 32'd0);
    check("rd_count", fetchCount, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
